// File: rtl/dds_core_gen2_if.sv
// Configuration, strobe and sample bus between the register file / LUT side
// (master) and the DDS core (slave).
interface dds_core_gen2_if #(
  parameter int PHASE_W    = 24,
  parameter int ADDR_W     = 8,
  parameter int SAMPLE_W   = 8,
  parameter int GAIN_W     = 4,
  parameter int WAVE_WIDTH = 16
);
  logic                  enable_i;
  logic                  tick_i;
  logic                  sync_i;
  logic                  cfg_load_i;
  logic [PHASE_W-1:0]    tuning_word_i;
  logic [PHASE_W-1:0]    phase_off_i;
  logic [2:0]            src_i;
  logic [ADDR_W-1:0]     duty_i;
  logic [GAIN_W-1:0]     gain_i;
  logic [WAVE_WIDTH-1:0] offset_i;
  logic [ADDR_W-1:0]     lut_addr_o;
  logic [SAMPLE_W-1:0]   lut_data_i;
  logic                  cfg_pending_o;
  logic [WAVE_WIDTH-1:0] wave_o;
  logic                  valid_o;

  modport master (
    output enable_i, tick_i, sync_i, cfg_load_i, tuning_word_i, phase_off_i,
           src_i, duty_i, gain_i, offset_i, lut_data_i,
    input  lut_addr_o, cfg_pending_o, wave_o, valid_o
  );

  modport slave (
    input  enable_i, tick_i, sync_i, cfg_load_i, tuning_word_i, phase_off_i,
           src_i, duty_i, gain_i, offset_i, lut_data_i,
    output lut_addr_o, cfg_pending_o, wave_o, valid_o
  );
endinterface

// File: rtl/dds_core_gen2.sv
// Tick-driven DDS generator: phase accumulator, five waveform sources, gain and
// saturating offset, with shadow/active config swapped only at safe points.
module dds_core_gen2 #(
  parameter int PHASE_W    = 24,
  parameter int ADDR_W     = 8,
  parameter int SAMPLE_W   = 8,
  parameter int GAIN_W     = 4,
  parameter int WAVE_WIDTH = 16
) (
  input logic            wb_clk_i,
  input logic            wb_rst_n_i,
  dds_core_gen2_if.slave bus
);
  localparam int PROD_W = SAMPLE_W + GAIN_W;

  typedef enum logic [2:0] {
    SRC_SINE   = 3'd0,
    SRC_SAW    = 3'd1,
    SRC_TRI    = 3'd2,
    SRC_SQUARE = 3'd3,
    SRC_RANDOM = 3'd4
  } src_e;

  typedef struct packed {
    logic [PHASE_W-1:0]    tuning;
    logic [PHASE_W-1:0]    phase_off;
    logic [2:0]            src;
    logic [ADDR_W-1:0]     duty;
    logic [GAIN_W-1:0]     gain;
    logic [WAVE_WIDTH-1:0] offset;
  } cfg_t;

  cfg_t                  cfg_in, shadow_r, active_r;
  logic                  pending_r;
  logic [PHASE_W-1:0]    phase_r;
  logic [PHASE_W:0]      phase_sum;
  logic                  accept, wrap, apply;
  logic [15:0]           lfsr_r;
  logic                  lfsr_fb;
  logic                  v0_r, v1_r, v2_r, valid_r;
  logic [2:0]            src0_r;
  logic [ADDR_W-1:0]     duty0_r;
  logic [PHASE_W-1:0]    poff0_r;
  logic [GAIN_W-1:0]     gain0_r, gain1_r;
  logic [WAVE_WIDTH-1:0] offset0_r, offset1_r, offset2_r;
  logic [ADDR_W-1:0]     addr;
  logic [ADDR_W-1:0]     tri_full;
  logic [SAMPLE_W-1:0]   sample_w, sample_r;
  logic [PROD_W-1:0]     prod_r;
  logic [WAVE_WIDTH:0]   sum_w;
  logic [WAVE_WIDTH-1:0] wave_r;

  always_comb begin
    cfg_in           = '0;
    cfg_in.tuning    = bus.tuning_word_i;
    cfg_in.phase_off = bus.phase_off_i;
    cfg_in.src       = bus.src_i;
    cfg_in.duty      = bus.duty_i;
    cfg_in.gain      = bus.gain_i;
    cfg_in.offset    = bus.offset_i;
  end

  assign phase_sum = {1'b0, phase_r} + {1'b0, active_r.tuning};
  assign accept    = bus.tick_i & bus.enable_i & ~bus.sync_i;
  assign wrap      = accept & phase_sum[PHASE_W];
  assign apply     = bus.sync_i | ~bus.enable_i | wrap;
  assign lfsr_fb   = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

  // A new load always wins over a same-cycle swap, discarding the old shadow.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      shadow_r  <= '0;
      active_r  <= '0;
      pending_r <= 1'b0;
    end else if (bus.cfg_load_i) begin
      shadow_r  <= cfg_in;
      pending_r <= 1'b1;
    end else if (apply && pending_r) begin
      active_r  <= shadow_r;
      pending_r <= 1'b0;
    end
  end

  // The accepted tick latches the config it was issued under, so a swap on the
  // same edge never leaks into a sample that is already in flight.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      phase_r   <= '0;
      lfsr_r    <= 16'h0001;
      v0_r      <= 1'b0;
      src0_r    <= SRC_SINE;
      duty0_r   <= '0;
      poff0_r   <= '0;
      gain0_r   <= '0;
      offset0_r <= '0;
    end else begin
      v0_r <= accept;
      if (bus.sync_i)
        phase_r <= '0;
      else if (accept)
        phase_r <= phase_sum[PHASE_W-1:0];
      if (accept) begin
        lfsr_r    <= {lfsr_r[14:0], lfsr_fb};
        src0_r    <= active_r.src;
        duty0_r   <= active_r.duty;
        poff0_r   <= active_r.phase_off;
        gain0_r   <= active_r.gain;
        offset0_r <= active_r.offset;
      end
    end
  end

  assign addr     = ADDR_W'((phase_r + poff0_r) >> (PHASE_W - ADDR_W));
  assign tri_full = {addr[ADDR_W-2:0], 1'b0} ^ {ADDR_W{addr[ADDR_W-1]}};

  always_comb begin
    sample_w = '0;
    case (src0_r)
      SRC_SINE:   sample_w = bus.lut_data_i;
      SRC_SAW:    sample_w = addr[ADDR_W-1 -: SAMPLE_W];
      SRC_TRI:    sample_w = SAMPLE_W'(tri_full >> (ADDR_W - SAMPLE_W));
      SRC_SQUARE: sample_w = (addr < duty0_r) ? '1 : '0;
      SRC_RANDOM: sample_w = lfsr_r[SAMPLE_W-1:0];
      default:    sample_w = '0;
    endcase
  end

  assign sum_w = (WAVE_WIDTH+1)'(prod_r) + {1'b0, offset2_r};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      valid_r   <= 1'b0;
      sample_r  <= '0;
      gain1_r   <= '0;
      offset1_r <= '0;
      prod_r    <= '0;
      offset2_r <= '0;
      wave_r    <= '0;
    end else begin
      v1_r    <= v0_r;
      v2_r    <= v1_r;
      valid_r <= v2_r;
      if (v0_r) begin
        sample_r  <= sample_w;
        gain1_r   <= gain0_r;
        offset1_r <= offset0_r;
      end
      if (v1_r) begin
        prod_r    <= PROD_W'(sample_r) * PROD_W'(gain1_r);
        offset2_r <= offset1_r;
      end
      if (v2_r)
        wave_r <= sum_w[WAVE_WIDTH] ? '1 : sum_w[WAVE_WIDTH-1:0];
    end
  end

  assign bus.lut_addr_o    = addr;
  assign bus.cfg_pending_o = pending_r;
  assign bus.wave_o        = wave_r;
  assign bus.valid_o       = valid_r;
endmodule

// File: tb/tb_dds_core_gen2.sv
// Directed bench for dds_core_gen2: hand-computed samples for each source,
// latency, config double buffering, saturation and reset flush.
module tb_dds_core_gen2;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int tests_run    = 0;
  int tests_failed = 0;

  dds_core_gen2_if bus ();

  dds_core_gen2 dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Recognisable sine LUT stand-in.
  assign bus.lut_data_i = bus.lut_addr_o ^ 8'h5A;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [23:0] tw, input logic [23:0] po, input logic [2:0] src,
                          input logic [7:0] duty, input logic [3:0] gain, input logic [15:0] off);
    bus.tuning_word_i = tw;
    bus.phase_off_i   = po;
    bus.src_i         = src;
    bus.duty_i        = duty;
    bus.gain_i        = gain;
    bus.offset_i      = off;
    bus.cfg_load_i    = 1'b1;
    step();
    bus.cfg_load_i    = 1'b0;
  endtask

  task automatic idle_cfg(input logic [23:0] tw, input logic [23:0] po, input logic [2:0] src,
                          input logic [7:0] duty, input logic [3:0] gain, input logic [15:0] off);
    bus.enable_i = 1'b0;
    load_cfg(tw, po, src, duty, gain, off);
    step();
    bus.enable_i = 1'b1;
  endtask

  task automatic sync_pulse();
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
  endtask

  // One tick, then the valid flag after each of the next three edges and the final sample.
  task automatic run_tick(output logic [2:0] vpat, output logic [15:0] w);
    bus.tick_i = 1'b1;
    step();
    bus.tick_i = 1'b0;
    step();
    vpat[0] = bus.valid_o;
    step();
    vpat[1] = bus.valid_o;
    step();
    vpat[2] = bus.valid_o;
    w = bus.wave_o;
  endtask

  task automatic test_reset();
    step();
    step();
    tests_run++;
    if (bus.wave_o !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_wave: got %h expected 0000", bus.wave_o);
    end
    tests_run++;
    if (bus.valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid_o);
    end
    tests_run++;
    if (bus.cfg_pending_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pending: got %b expected 0", bus.cfg_pending_o);
    end
    tests_run++;
    if (bus.lut_addr_o !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_lut_addr: got %h expected 00", bus.lut_addr_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_saw_ramp();
    logic [2:0]  vpat;
    logic [15:0] w;
    logic [15:0] exp_w;
    bus.enable_i = 1'b0;
    load_cfg(24'h010000, 24'h0, 3'd1, 8'h00, 4'd1, 16'h0000);
    tests_run++;
    if (bus.cfg_pending_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL idle_pending_set: got %b expected 1", bus.cfg_pending_o);
    end
    step();
    tests_run++;
    if (bus.cfg_pending_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_pending_clear: got %b expected 0", bus.cfg_pending_o);
    end
    bus.enable_i = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      run_tick(vpat, w);
      exp_w = 16'(k % 256);
      tests_run++;
      if (vpat !== 3'b100) begin
        tests_failed++;
        $display("[TB] FAIL saw_latency[%0d]: got %b expected 100", k, vpat);
      end
      tests_run++;
      if (w !== exp_w) begin
        tests_failed++;
        $display("[TB] FAIL saw_value[%0d]: got %h expected %h", k, w, exp_w);
      end
    end
  endtask

  task automatic test_config_swap();
    logic [2:0]  vpat;
    logic [15:0] w;
    for (int k = 1; k <= 10; k++) begin
      run_tick(vpat, w);
      tests_run++;
      if (w !== 16'(k)) begin
        tests_failed++;
        $display("[TB] FAIL swap_pre[%0d]: got %h expected %h", k, w, 16'(k));
      end
    end
    load_cfg(24'h020000, 24'h0, 3'd1, 8'h00, 4'd1, 16'h0000);
    tests_run++;
    if (bus.cfg_pending_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL swap_pending_set: got %b expected 1", bus.cfg_pending_o);
    end
    for (int k = 11; k <= 255; k++) begin
      run_tick(vpat, w);
      tests_run++;
      if (w !== 16'(k) || bus.cfg_pending_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL swap_hold[%0d]: got %h/%b expected %h/1", k, w, bus.cfg_pending_o, 16'(k));
      end
    end
    bus.tick_i = 1'b1;
    step();
    bus.tick_i = 1'b0;
    tests_run++;
    if (bus.cfg_pending_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL swap_pending_wrap: got %b expected 0", bus.cfg_pending_o);
    end
    step();
    step();
    step();
    tests_run++;
    if (bus.valid_o !== 1'b1 || bus.wave_o !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL swap_wrap_value: got %h/%b expected 0000/1", bus.wave_o, bus.valid_o);
    end
    run_tick(vpat, w);
    tests_run++;
    if (w !== 16'h0002) begin
      tests_failed++;
      $display("[TB] FAIL swap_new_step1: got %h expected 0002", w);
    end
    run_tick(vpat, w);
    tests_run++;
    if (w !== 16'h0004) begin
      tests_failed++;
      $display("[TB] FAIL swap_new_step2: got %h expected 0004", w);
    end
  endtask

  task automatic test_sync_tick();
    logic [2:0]  vpat;
    logic [15:0] w;
    idle_cfg(24'h010000, 24'h0, 3'd1, 8'h00, 4'd1, 16'h0000);
    bus.sync_i = 1'b1;
    bus.tick_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    bus.tick_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (bus.valid_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL sync_drop[%0d]: got %b expected 0", i, bus.valid_o);
      end
    end
    run_tick(vpat, w);
    tests_run++;
    if (vpat !== 3'b100 || w !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL sync_restart: got %b/%h expected 100/0001", vpat, w);
    end
  endtask

  task automatic test_gain_offset();
    logic [2:0]  vpat;
    logic [15:0] w;
    logic [3:0]  gains [4] = '{4'd15, 4'd15, 4'd15, 4'd0};
    logic [15:0] offs  [4] = '{16'h0000, 16'hF000, 16'hFF00, 16'h1234};
    logic [15:0] exps  [4] = '{16'h0EF1, 16'hFEF1, 16'hFFFF, 16'h1234};
    for (int i = 0; i < 4; i++) begin
      idle_cfg(24'hFF0000, 24'h0, 3'd1, 8'h00, gains[i], offs[i]);
      sync_pulse();
      run_tick(vpat, w);
      tests_run++;
      if (w !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL gain_offset[%0d]: got %h expected %h", i, w, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_valid, n_ff, n_00, n_other;
    idle_cfg(24'h010000, 24'h0, 3'd3, 8'h40, 4'd1, 16'h0000);
    sync_pulse();
    n_valid = 0; n_ff = 0; n_00 = 0; n_other = 0;
    for (int i = 0; i < 259; i++) begin
      bus.tick_i = (i < 256) ? 1'b1 : 1'b0;
      step();
      if (bus.valid_o === 1'b1) begin
        n_valid++;
        if (bus.wave_o === 16'h00FF) n_ff++;
        else if (bus.wave_o === 16'h0000) n_00++;
        else n_other++;
      end
    end
    bus.tick_i = 1'b0;
    tests_run++;
    if (n_valid != 256) begin
      tests_failed++;
      $display("[TB] FAIL square_throughput: got %0d expected 256", n_valid);
    end
    tests_run++;
    if (n_ff != 64 || n_00 != 192 || n_other != 0) begin
      tests_failed++;
      $display("[TB] FAIL square_duty: got %0d/%0d/%0d expected 64/192/0", n_ff, n_00, n_other);
    end
    idle_cfg(24'h010000, 24'h0, 3'd3, 8'h00, 4'd1, 16'h0000);
    sync_pulse();
    n_valid = 0; n_other = 0;
    for (int i = 0; i < 19; i++) begin
      bus.tick_i = (i < 16) ? 1'b1 : 1'b0;
      step();
      if (bus.valid_o === 1'b1) begin
        n_valid++;
        if (bus.wave_o !== 16'h0000) n_other++;
      end
    end
    bus.tick_i = 1'b0;
    tests_run++;
    if (n_valid != 16 || n_other != 0) begin
      tests_failed++;
      $display("[TB] FAIL square_duty0: got %0d valid/%0d nonzero expected 16/0", n_valid, n_other);
    end
  endtask

  task automatic test_other_sources();
    logic [2:0]  vpat;
    logic [15:0] w;
    idle_cfg(24'h010000, 24'h100000, 3'd0, 8'h00, 4'd1, 16'h0000);
    sync_pulse();
    run_tick(vpat, w);
    tests_run++;
    if (w !== 16'h004B) begin
      tests_failed++;
      $display("[TB] FAIL sine_lut: got %h expected 004b", w);
    end
    idle_cfg(24'h010000, 24'h0, 3'd5, 8'h00, 4'd1, 16'h0000);
    sync_pulse();
    run_tick(vpat, w);
    tests_run++;
    if (vpat !== 3'b100 || w !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reserved_src: got %b/%h expected 100/0000", vpat, w);
    end
    idle_cfg(24'h7F0000, 24'h0, 3'd2, 8'h00, 4'd1, 16'h0000);
    sync_pulse();
    run_tick(vpat, w);
    tests_run++;
    if (w !== 16'h00FE) begin
      tests_failed++;
      $display("[TB] FAIL tri_rise: got %h expected 00fe", w);
    end
    run_tick(vpat, w);
    tests_run++;
    if (w !== 16'h0003) begin
      tests_failed++;
      $display("[TB] FAIL tri_fall: got %h expected 0003", w);
    end
  endtask

  task automatic test_reset_flush();
    logic [2:0]  vpat;
    logic [15:0] w;
    idle_cfg(24'h010000, 24'h0, 3'd1, 8'h00, 4'd1, 16'h0100);
    sync_pulse();
    for (int i = 0; i < 3; i++) begin
      bus.tick_i = 1'b1;
      step();
    end
    bus.tick_i = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.wave_o !== 16'h0000 || bus.valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_immediate: got %h/%b expected 0000/0", bus.wave_o, bus.valid_o);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++;
      if (bus.valid_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL flush_no_valid[%0d]: got %b expected 0", i, bus.valid_o);
      end
    end
    idle_cfg(24'h010000, 24'h0, 3'd4, 8'h00, 4'd1, 16'h0000);
    run_tick(vpat, w);
    tests_run++;
    if (vpat !== 3'b100 || w !== 16'h0002) begin
      tests_failed++;
      $display("[TB] FAIL random_first: got %b/%h expected 100/0002", vpat, w);
    end
    run_tick(vpat, w);
    tests_run++;
    if (w !== 16'h0004) begin
      tests_failed++;
      $display("[TB] FAIL random_second: got %h expected 0004", w);
    end
  endtask

  initial begin
    bus.enable_i      = 1'b0;
    bus.tick_i        = 1'b0;
    bus.sync_i        = 1'b0;
    bus.cfg_load_i    = 1'b0;
    bus.tuning_word_i = '0;
    bus.phase_off_i   = '0;
    bus.src_i         = '0;
    bus.duty_i        = '0;
    bus.gain_i        = '0;
    bus.offset_i      = '0;
    test_reset();
    test_saw_ramp();
    test_config_swap();
    test_sync_tick();
    test_gain_offset();
    test_back_to_back();
    test_other_sources();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
